// File: rtl/psum_write_controller_pkg.sv
// rtl/psum_write_controller_pkg.sv - shared PE psum write-back definitions
package psum_write_controller_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int PSUM_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LATCH = 3'd2,
        S_WAIT  = 3'd3,
        S_PUSH  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/psum_write_controller_addr_counter.sv
// rtl/psum_write_controller_addr_counter.sv - psum scratchpad address counter with carry-out at len-1
module psum_addr_counter
    import psum_write_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W:0]   len_q,
    output logic [ADDR_W-1:0] addr,
    output logic              co
);

    localparam logic [ADDR_W:0] ONE_L = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Holding at the last entry keeps a full 2^ADDR_W pass from wrapping to 0.
    assign co   = ({1'b0, addr_q} == (len_q - ONE_L));
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (inc && !co) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/psum_write_controller.sv
// rtl/psum_write_controller.sv - drains psum scratchpad into the PE output FIFO, optionally clearing entries
module psum_write_controller
    import psum_write_controller_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int PSUM_W        = PSUM_W_DEF,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_write,
    input  logic [ADDR_W:0]   psum_len,
    input  logic [PSUM_W-1:0] spad_rdata,
    input  logic              out_full,
    output logic              spad_ren,
    output logic              spad_wen,
    output logic [ADDR_W-1:0] spad_addr,
    output logic [PSUM_W-1:0] spad_wdata,
    output logic              out_wen,
    output logic [PSUM_W-1:0] out_data,
    output logic              busy,
    output logic              finish_write
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [PSUM_W-1:0] data_q, data_d;
    logic              finish_q;
    logic [ADDR_W-1:0] addr;
    logic              co;

    psum_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state_q == S_IDLE) && start_write),
        .inc   (state_q == S_PUSH),
        .len_q (len_q),
        .addr  (addr),
        .co    (co)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_write) begin
                    len_d   = (psum_len > MAX_LEN) ? MAX_LEN : psum_len;
                    state_d = (psum_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD:    state_d = S_LATCH;
            S_LATCH: begin
                data_d  = spad_rdata;
                state_d = S_WAIT;
            end
            S_WAIT:  if (!out_full) state_d = S_PUSH;
            S_PUSH:  state_d = co ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            data_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            data_q   <= data_d;
            finish_q <= (state_q == S_DONE);
        end
    end

    // Strobes are masked by rst so a reset landing on PUSH/LATCH issues nothing.
    assign spad_ren     = !rst && (state_q == S_RD);
    assign spad_wen     = CLEAR_ON_READ && !rst && (state_q == S_LATCH);
    assign out_wen      = !rst && (state_q == S_PUSH);
    assign busy         = !rst && (state_q != S_IDLE);
    assign finish_write = !rst && finish_q;
    assign spad_addr    = addr;
    assign spad_wdata   = '0;
    assign out_data     = data_q;

endmodule

// File: tb/tb_psum_write_controller.sv
// tb/tb_psum_write_controller.sv - self-checking bench for psum_write_controller
module tb_psum_write_controller;

    localparam int AW    = 4;
    localparam int PW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_write;
    logic [AW:0]   psum_len;
    logic [PW-1:0] spad_rdata;
    logic          out_full;
    logic          spad_ren;
    logic          spad_wen;
    logic [AW-1:0] spad_addr;
    logic [PW-1:0] spad_wdata;
    logic          out_wen;
    logic [PW-1:0] out_data;
    logic          busy;
    logic          finish_write;

    always #5 clk = ~clk;

    psum_write_controller #(.ADDR_W(AW), .PSUM_W(PW), .CLEAR_ON_READ(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_write  (start_write),
        .psum_len     (psum_len),
        .spad_rdata   (spad_rdata),
        .out_full     (out_full),
        .spad_ren     (spad_ren),
        .spad_wen     (spad_wen),
        .spad_addr    (spad_addr),
        .spad_wdata   (spad_wdata),
        .out_wen      (out_wen),
        .out_data     (out_data),
        .busy         (busy),
        .finish_write (finish_write)
    );

    // Scratchpad model: 1-cycle read latency, write port used by the clear
    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] img [DEPTH];
    logic [PW-1:0] snap [DEPTH];
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else begin
            if (spad_ren) spad_rdata <= mem[spad_addr];
            if (spad_wen) mem[spad_addr] <= spad_wdata;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_image(input bit fixed);
        for (int i = 0; i < DEPTH; i++) img[i] = 16'($urandom);
        if (fixed) begin
            img[0] = 16'd3; img[1] = 16'd5; img[2] = 16'd7; img[3] = 16'd9;
        end
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
    endtask

    task automatic run_pass(input string tag, input int len, input int stall_idx,
                            input int stall_cyc, input int restart_at,
                            input int exp_pushes, input int exp_finish);
        int push_t[$];
        logic [PW-1:0] push_d[$];
        int rd_a[$];
        int finishes = 0;
        int fin_t = -1;
        int overlap = 0;
        int bad_mem = 0;
        int exp_t;
        @(posedge clk); #1;
        for (int t = 0; t < 400; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            start_write = (t == 0) || (t == restart_at);
            psum_len    = (t == 0) ? 5'(len) : 5'($urandom);
            out_full    = (stall_idx >= 0) && (t >= 4*stall_idx + 3) && (t < 4*stall_idx + 3 + stall_cyc);
            if (spad_ren) rd_a.push_back(int'(spad_addr));
            if (out_wen) begin
                push_t.push_back(t);
                push_d.push_back(out_data);
            end
            if (int'(spad_ren) + int'(spad_wen) + int'(out_wen) > 1) overlap++;
            if (finish_write) begin
                finishes++;
                if (fin_t < 0) fin_t = t;
            end
            if (fin_t >= 0 && t >= fin_t + 3) break;
        end
        start_write = 1'b0;
        out_full    = 1'b0;
        check({tag, " push count"}, push_t.size(), exp_pushes);
        check({tag, " read count"}, rd_a.size(), exp_pushes);
        check({tag, " finish cycle"}, fin_t, exp_finish);
        check({tag, " finish pulses"}, finishes, 1);
        check({tag, " strobe overlap"}, overlap, 0);
        check({tag, " busy after"}, busy, 0);
        for (int k = 0; k < push_t.size() && k < exp_pushes; k++) begin
            exp_t = 4*(k+1) + ((stall_idx >= 0 && k >= stall_idx) ? stall_cyc : 0);
            check($sformatf("%s push%0d time", tag, k), push_t[k], exp_t);
            check($sformatf("%s push%0d data", tag, k), push_d[k], snap[k]);
        end
        for (int k = 0; k < rd_a.size() && k < exp_pushes; k++)
            check($sformatf("%s read%0d addr", tag, k), rd_a[k], k);
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ((i < exp_pushes) ? 16'd0 : snap[i])) bad_mem++;
        check({tag, " clear image"}, bad_mem, 0);
    endtask

    typedef struct {
        string name;
        int len;
        int stall_idx;
        int stall_cyc;
        int restart_at;
        int exp_pushes;
        int exp_finish;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        int sidx;
        int scyc;
        int fin;
        int ev;
        rst         = 1'b1;
        start_write = 1'b0;
        psum_len    = '0;
        out_full    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset out_data", out_data, 0);
        check("reset spad_addr", spad_addr, 0);
        check("reset strobes", {spad_ren, spad_wen, out_wen, finish_write}, 0);

        vecs.push_back('{"basic",      4, -1, 0, -1,  4, 18});
        vecs.push_back('{"backpress",  4,  1, 5, -1,  4, 23});
        vecs.push_back('{"zero",       0, -1, 0, -1,  0,  2});
        vecs.push_back('{"full16",    16, -1, 0, -1, 16, 66});
        vecs.push_back('{"restart",    5, -1, 0,  6,  5, 22});
        vecs.push_back('{"clamp31",   31, -1, 0, -1, 16, 66});
        vecs.push_back('{"single",     1,  0, 3, -1,  1,  9});
        vecs.push_back('{"clamp20",   20,  2, 1, -1, 16, 67});
        for (int v = 0; v < vecs.size(); v++) begin
            load_image(v == 0);
            run_pass(vecs[v].name, vecs[v].len, vecs[v].stall_idx, vecs[v].stall_cyc,
                     vecs[v].restart_at, vecs[v].exp_pushes, vecs[v].exp_finish);
        end

        for (int r = 0; r < 6; r++) begin
            n    = $urandom_range(0, 20);
            ev   = (n > DEPTH) ? DEPTH : n;
            sidx = (ev > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, ev - 1) : -1;
            scyc = $urandom_range(1, 4);
            fin  = (ev == 0) ? 2 : 4*ev + 2 + ((sidx >= 0) ? scyc : 0);
            load_image(1'b0);
            run_pass($sformatf("rand%0d", r), n, sidx, scyc, -1, ev, fin);
        end

        // Reset landing on the PUSH of entry 1 aborts the pass
        load_image(1'b0);
        @(posedge clk); #1;
        for (int t = 0; t < 10; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            start_write = (t == 0);
            psum_len    = 5'd4;
            rst         = (t == 8) || (t == 9);
            #1;
            if (t >= 8) begin
                check($sformatf("rst cycle%0d no push", t), out_wen, 0);
                check($sformatf("rst cycle%0d no clear", t), spad_wen, 0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post-rst busy", busy, 0);
        check("post-rst out_data", out_data, 0);
        check("post-rst spad_addr", spad_addr, 0);
        check("post-rst strobes", {spad_ren, spad_wen, out_wen, finish_write}, 0);
        ev = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (out_wen || finish_write || busy || spad_ren) ev++;
        end
        check("post-rst quiet", ev, 0);
        check("rst entry0 cleared", mem[0], 0);
        check("rst entry2 kept", mem[2], snap[2]);
        check("rst entry3 kept", mem[3], snap[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/psum_write_controller.md
# psum_write_controller

Write-back controller for the PE's partial-sum path. It runs once per start pulse. Each pass reads a run-time number of partial sums from the PE psum scratchpad and pushes them, in address order, into the PE output FIFO, stalling while that FIFO is full. It can optionally zero each scratchpad entry as it is drained. It sits between the psum scratchpad and the output FIFO, and is the outbound counterpart of the PE's input-side read controllers.

## Interface
Parameters:
- ADDR_W, 4, psum scratchpad address width
- PSUM_W, 16, partial-sum data width
- CLEAR_ON_READ, 1, when 1, each drained entry is overwritten with zero

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_write  input  1  one-cycle start request; sampled only in IDLE
- psum_len  input  ADDR_W+1  number of psums to drain; sampled with start_write
- spad_rdata  input  PSUM_W  scratchpad read data, valid one cycle after spad_ren
- out_full  input  1  output FIFO full
- spad_ren  output  1  scratchpad read enable
- spad_wen  output  1  scratchpad write enable (clear-on-read)
- spad_addr  output  ADDR_W  scratchpad address, shared by read and clear
- spad_wdata  output  PSUM_W  scratchpad write data; always zero
- out_wen  output  1  output FIFO push
- out_data  output  PSUM_W  data to output FIFO
- busy  output  1  high in every state except IDLE
- finish_write  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RD, LATCH, WAIT, PUSH, DONE. Moore outputs are derived from the present state only.
- IDLE: all strobes low.
  - On start_write: latch len_q = psum_len and clear addr to 0.
  - If psum_len == 0, go to DONE. Otherwise go to RD.
- RD: spad_ren = 1, spad_addr = addr. Next state is LATCH.
- LATCH: data_q <= spad_rdata. When CLEAR_ON_READ = 1, also assert spad_wen = 1 at the same addr. Next state is WAIT.
- WAIT: stay while out_full = 1. When out_full = 0, go to PUSH.
- PUSH:
  - Assert out_wen = 1, with out_data = data_q.
  - co = (addr == len_q − 1).
  - If co, go to DONE. Otherwise addr <= addr + 1 and go to RD.
- DONE: finish_write = 1 for exactly one cycle. Next state is IDLE.
- Outputs:
  - out_data always drives data_q.
  - spad_addr always drives addr.
  - spad_wdata is constant 0.
- Arithmetic:
  - addr is ADDR_W bits wide.
  - len_q is ADDR_W+1 bits wide, so 2^ADDR_W entries are legal.
  - psum_len > 2^ADDR_W is clamped to 2^ADDR_W.
- start_write outside IDLE is ignored. It is neither queued nor restarts the pass.
- psum_len changes after the start cycle have no effect.

## Timing
- Reset:
  - State goes to IDLE.
  - addr, len_q and data_q go to 0.
  - All strobes (spad_ren, spad_wen, out_wen, finish_write, busy) are 0.
  - out_data is 0.
- Reset mid-pass aborts immediately. No push or clear is issued in the reset cycle or the cycle after. Entries not yet drained keep their contents.
- Scratchpad read latency is exactly 1 cycle: data is captured in LATCH.
- Throughput with out_full = 0 is 1 push per 4 cycles (RD, LATCH, WAIT, PUSH).
- Latency from the start_write cycle to finish_write is 4·N + 2 cycles for N ≥ 1, and 2 cycles for N = 0.
- out_full is sampled in WAIT only. A deassertion in the same cycle it was seen high costs one extra WAIT cycle. PUSH does not re-check out_full: the FIFO must not go full between the WAIT exit and the PUSH.
- The clear write (LATCH) happens at the same address and in the cycle after the read. A pass aborted by reset between LATCH and PUSH loses that one entry.
- At most one of spad_ren, spad_wen or out_wen is high in any cycle, except none overlap by construction.

## Structure
- Shared PE definitions include: ADDR_W, PSUM_W defaults and the state encoding constants (3-bit).
- One sub-module, psum_addr_counter:
  - Ports: clr, inc, len_q; outputs addr and co.
  - Same counter style as the other PE counters.
- The FSM and the data_q register stay in the top module.

## Test plan
- Reset: drive rst for 2 cycles mid-pass -> next cycle all outputs are 0, state is IDLE, busy = 0, and no out_wen follows.
- Basic drain: spad holds 3,5,7,9 and psum_len = 4 with out_full = 0 -> four pushes of 3,5,7,9 at cycles 4,8,12,16 after start, and finish_write at cycle 18. With CLEAR_ON_READ = 1, all four entries read back 0.
- Backpressure: out_full = 1 for 5 cycles during the second WAIT -> the push sequence and data are unchanged, and the total latency is 23 cycles.
- Zero length: psum_len = 0 -> no spad_ren and no out_wen; finish_write 2 cycles after start.
- Full length and wrap: ADDR_W = 4, psum_len = 16 -> addresses 0..15 are drained once each, addr never wraps past 15, and exactly 16 pushes occur.
- Ignored start: a second start_write pulse mid-pass -> no effect, and a single finish_write.
